compute_max_disp: RTL and testbench

Block-matching disparity engine for the stereo pipeline. It takes a WIN-row band of the left and right images and a window column. It computes the sum of absolute differences (SAD) between the left WIN×WIN window and each disparity-shifted right window, then reports the disparity with the minimum SAD. Each input_ready starts one disparity computation; done is pulsed high and held when the result is ready.

---
 rtl/compute_max_disp_if.sv | 45 ++++
 rtl/compute_max_disp.sv | 131 +++++++++++++
 tb/tb_compute_max_disp.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/compute_max_disp_if.sv
// Handshake and data bundle for the block-matching disparity engine.
// Defining SAD_OUT_EN adds the best_sad result field.
interface compute_max_disp_if #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 64
);
  localparam int SAD_BITS  = $clog2(WIN*WIN*((1<<DATA_SIZE)-1)+1);
  localparam int DISP_BITS = $clog2(MAX_DISP);
  localparam int IMG_W_ARR = $clog2(IMG_W);
  localparam int ARR_W     = DATA_SIZE*IMG_W*WIN;

  logic [ARR_W-1:0]     input_array_L;
  logic [ARR_W-1:0]     input_array_R;
  logic                 input_ready;
  logic [IMG_W_ARR-1:0] col_index;
  logic [DISP_BITS-1:0] output_disp;
  logic                 done;
`ifdef SAD_OUT_EN
  logic [SAD_BITS-1:0]  best_sad;

  modport master (
    output input_array_L, input_array_R,
    output input_ready, col_index,
    input  output_disp, done, best_sad
  );
  modport slave (
    input  input_array_L, input_array_R,
    input  input_ready, col_index,
    output output_disp, done, best_sad
  );
`else
  modport master (
    output input_array_L, input_array_R,
    output input_ready, col_index,
    input  output_disp, done
  );
  modport slave (
    input  input_array_L, input_array_R,
    input  input_ready, col_index,
    output output_disp, done
  );
`endif
endinterface

// File: rtl/compute_max_disp.sv
// SAD block-matching disparity search, one candidate per clock.
// Optional macro SAD_OUT_EN exports the winning SAD as best_sad.
module compute_max_disp #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 64
) (
  input logic              clk,
  input logic              rst,
  compute_max_disp_if.slave bus
);
  localparam int SAD_BITS  = $clog2(WIN*WIN*((1<<DATA_SIZE)-1)+1);
  localparam int DISP_BITS = $clog2(MAX_DISP);
  localparam int IMG_W_ARR = $clog2(IMG_W);
  localparam int ARR_W     = DATA_SIZE*IMG_W*WIN;
  localparam int CNT_W     = DISP_BITS+1;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [ARR_W-1:0]     arr_l;
  logic [ARR_W-1:0]     arr_r;
  logic [IMG_W_ARR-1:0] col_q;
  logic [CNT_W-1:0]     d_q;
  logic [CNT_W-1:0]     n_cand;
  logic [SAD_BITS-1:0]  sad;
  logic [SAD_BITS-1:0]  best_sad;
  logic [DISP_BITS-1:0] best_d;
  logic [DISP_BITS-1:0] disp_q;
  logic                 done_q;
  logic                 start;

  // Columns past the row end only occur for invalid candidates.
  function automatic logic [DATA_SIZE-1:0] pix(
    input logic [ARR_W-1:0] a,
    input int               r,
    input int               c
  );
    int cc;
    cc = (c < IMG_W) ? c : 0;
    return a[(r*IMG_W+cc)*DATA_SIZE +: DATA_SIZE];
  endfunction

  assign start = bus.input_ready && (state != COMPUTE);

  // Number of candidates whose right window stays inside the row.
  always_comb begin
    n_cand = CNT_W'(MAX_DISP);
    if (int'(col_q) > IMG_W - WIN)
      n_cand = '0;
    else if (IMG_W - WIN + 1 - int'(col_q) < MAX_DISP)
      n_cand = CNT_W'(IMG_W - WIN + 1 - int'(col_q));
  end

  // SAD of the current candidate over the full window.
  always_comb begin
    sad = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int j = 0; j < WIN; j++) begin
        logic [DATA_SIZE-1:0] lp;
        logic [DATA_SIZE-1:0] rp;
        lp  = pix(arr_l, r, int'(col_q) + j);
        rp  = pix(arr_r, r, int'(col_q) + int'(d_q) + j);
        sad = sad + SAD_BITS'(lp > rp ? lp - rp : rp - lp);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.input_ready) state_n = COMPUTE;
      COMPUTE: if (d_q == n_cand)   state_n = DONE;
      DONE:    if (bus.input_ready) state_n = COMPUTE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, best-candidate tracking and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_l    <= '0;
      arr_r    <= '0;
      col_q    <= '0;
      d_q      <= '0;
      best_sad <= '1;
      best_d   <= '0;
      disp_q   <= '0;
      done_q   <= 1'b0;
    end else if (start) begin
      arr_l    <= bus.input_array_L;
      arr_r    <= bus.input_array_R;
      col_q    <= bus.col_index;
      d_q      <= '0;
      best_sad <= '1;
      best_d   <= '0;
      done_q   <= 1'b0;
    end else if (state == COMPUTE) begin
      if (d_q != n_cand) begin
        if (sad < best_sad) begin
          best_sad <= sad;
          best_d   <= d_q[DISP_BITS-1:0];
        end
        d_q <= d_q + 1'b1;
      end else begin
        disp_q <= best_d;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.output_disp = disp_q;
  assign bus.done        = done_q;
`ifdef SAD_OUT_EN
  assign bus.best_sad    = best_sad;
`endif

endmodule

// File: tb/tb_compute_max_disp.sv
// Randomized self-checking bench for compute_max_disp.
// Reference: brute-force SAD search over byte arrays.
module tb_compute_max_disp;
  localparam int WIN       = 15;
  localparam int DATA_SIZE = 8;
  localparam int IMG_W     = 64;
  localparam int MAX_DISP  = 64;
  localparam int ARR_W     = DATA_SIZE*IMG_W*WIN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  compute_max_disp_if #(
    .WIN(WIN), .DATA_SIZE(DATA_SIZE),
    .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)
  ) bus ();

  compute_max_disp #(
    .WIN(WIN), .DATA_SIZE(DATA_SIZE),
    .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] pl [WIN][IMG_W];
  logic [7:0] pr [WIN][IMG_W];

  task automatic check(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int n_of(int col);
    int n;
    n = IMG_W - WIN - col + 1;
    if (n < 0) n = 0;
    if (n > MAX_DISP) n = MAX_DISP;
    return n;
  endfunction

  function automatic int ref_disp(int col);
    int best;
    int bd;
    int s;
    best = -1;
    bd   = 0;
    for (int d = 0; d < n_of(col); d++) begin
      s = 0;
      for (int r = 0; r < WIN; r++)
        for (int c = col; c < col + WIN; c++)
          if (pl[r][c] > pr[r][c+d]) s += int'(pl[r][c]) - int'(pr[r][c+d]);
          else                       s += int'(pr[r][c+d]) - int'(pl[r][c]);
      if (best < 0 || s < best) begin
        best = s;
        bd   = d;
      end
    end
    return bd;
  endfunction

  task automatic pack();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        bus.input_array_L[(r*IMG_W+c)*8 +: 8] = pl[r][c];
        bus.input_array_R[(r*IMG_W+c)*8 +: 8] = pr[r][c];
      end
  endtask

  task automatic scramble();
    for (int i = 0; i < ARR_W/32; i++) begin
      bus.input_array_L[i*32 +: 32] = $urandom();
      bus.input_array_R[i*32 +: 32] = $urandom();
    end
    bus.col_index = 6'($urandom_range(0, 63));
  endtask

  task automatic fill_zero();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        pl[r][c] = 8'h00;
        pr[r][c] = 8'h00;
      end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        pl[r][c] = (c < WIN) ? 8'(r*WIN + c) : 8'h00;
        pr[r][c] = (c >= 7 && c < 7 + WIN) ? 8'(r*WIN + c - 7) : 8'hFF;
      end
  endtask

  task automatic fill_rand(int col);
    int dt;
    int n;
    n  = n_of(col);
    dt = (n > 0) ? int'($urandom_range(0, n - 1)) : 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        pl[r][c] = 8'($urandom());
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        pr[r][c] = (c >= dt) ? pl[r][c-dt] ^ 8'($urandom_range(0, 3))
                             : 8'($urandom());
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #10;
    rst = 1'b0;
  endtask

  task automatic start_op(int col);
    pack();
    bus.col_index = 6'(col);
    @(negedge clk);
    bus.input_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.input_ready = 1'b0;
    scramble();
  endtask

  task automatic run(string tag, int col, bit glitch);
    int exp_d;
    int exp_lat;
    int lat;
    int held;
    exp_d   = ref_disp(col);
    exp_lat = n_of(col) + 1;
    start_op(col);
    check({tag, ".clr"}, int'(bus.done), 0);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (glitch && exp_lat > 6 && lat == 3) bus.input_ready = 1'b1;
      if (lat == 4) bus.input_ready = 1'b0;
      if (bus.done) break;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".disp"}, int'(bus.output_disp), exp_d);
    repeat (3) @(posedge clk);
    #1;
    held = int'(bus.done) * 100 + int'(bus.output_disp);
    check({tag, ".hold"}, held, 100 + exp_d);
  endtask

  initial begin
    int seen;
    int col;
    rst = 1'b1;
    bus.input_ready = 1'b0;
    bus.col_index = '0;
    bus.input_array_L = '0;
    bus.input_array_R = '0;
    #12;
    check("rst.done", int'(bus.done), 0);
    check("rst.disp", int'(bus.output_disp), 0);
    @(negedge clk);
    rst = 1'b0;

    fill_zero();
    run("zero", 0, 1'b0);

    fill_ramp();
    run("ramp", 0, 1'b0);
    check("ramp.const", int'(bus.output_disp), 7);

    fill_rand(49);
    run("c49", 49, 1'b0);
    fill_rand(55);
    run("c55", 55, 1'b0);

    fill_ramp();
    run("ramp2", 0, 1'b0);
    start_op(0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.done", int'(bus.done), 0);
    check("arst.disp", int'(bus.output_disp), 0);
    #9;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    check("arst.idle", seen, 0);
    fill_ramp();
    run("rerun", 0, 1'b0);
    check("rerun.const", int'(bus.output_disp), 7);

    for (int k = 0; k < 4; k++) begin
      col = int'($urandom_range(0, 52));
      fill_rand(col);
      pulse_rst();
      run($sformatf("b2b%0d", k), col, 1'b1);
    end

    for (int k = 0; k < 3; k++) begin
      col = int'($urandom_range(0, 40));
      fill_rand(col);
      run($sformatf("chain%0d", k), col, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
